conv_band_buffer: RTL and testbench
===================================

// Module: conv_band_buffer
// PURPOSE
//  Parametrised row-band buffer feeding the conv MAC array. Accepts whole image rows
//  over a valid/ready stream and holds a band of DEPTH = OUT_ROWS+K-1 rows.
//  On request it returns a registered OUT_ROWS x OUT_W window shifted by
//  (ker_row, ker_col). On band_done it slides down OUT_ROWS rows and refills, so
//  K-1 overlap rows are reused rather than reloaded.
// PARAMETERS
//  DW        16  pixel width (bits)
//  IMG_W     32  pixels per input row
//  K          5  kernel size (rows = cols)
//  OUT_ROWS   4  output rows produced per band
//  localparam DEPTH = OUT_ROWS+K-1; OUT_W = IMG_W-K+1; CW = clog2(K); FW = clog2(DEPTH+1)
// PORTS
//  clk          in   1                 clock, all logic on rising edge
//  rst          in   1                 reset, synchronous, active-high
//  frame_start  in   1                 pulse: discard band contents, restart fill
//  in_valid     in   1                 in_row holds a valid row
//  in_ready     out  1                 buffer accepts a row this cycle
//  in_row       in   IMG_W*DW          row; pixel p at [p*DW +: DW]
//  buf_ready    out  1                 full band loaded, windows may be requested
//  win_req      in   1                 request a window for ker_row/ker_col
//  ker_row      in   CW                kernel row offset 0..K-1
//  ker_col      in   CW                kernel col offset 0..K-1
//  win_valid    out  1                 win_data valid (1-cycle pulse per request)
//  win_data     out  OUT_ROWS*OUT_W*DW row r, col c at [(r*OUT_W+c)*DW +: DW]
//  win_err      out  1                 sticky: request with offset >= K seen
//  band_done    in   1                 consumer finished band; slide by OUT_ROWS
// BEHAVIOUR
//  Storage: band[0..DEPTH-1]. Row 0 is the oldest/top row. fill_cnt is FW bits.
//  States:
//    FILL:  in_ready=1. On in_valid: band[fill_cnt]<=in_row and fill_cnt++.
//           Go to READY when fill_cnt reaches DEPTH (in the same cycle as the last write).
//    READY: in_ready=0, buf_ready=1. Serve win_req.
//           On band_done: band[i]<=band[i+OUT_ROWS] for i<K-1; fill_cnt<=K-1; go to FILL.
//  in_ready = (state==FILL) && !rst, combinational. buf_ready = (state==READY), registered.
//  Window, 1-cycle latency: a win_req in READY at cycle t gives win_valid=1 at t+1, with
//    win_data[r][c] = band[ker_row+r][ker_col+c], sampled from the pre-edge band at t.
//  win_req in FILL: ignored. No win_valid, win_data held.
//  Out-of-range offset (ker_row>=K or ker_col>=K) in READY: win_valid=1, win_data=0,
//    win_err<=1. win_err clears only on rst or frame_start.
//  win_data holds its last value between requests. win_valid is a single-cycle pulse.
//  band_done in FILL: ignored.
//  band_done together with win_req in READY: the window uses pre-slide rows, then the slide occurs.
//  Priority: rst > frame_start > band_done > in_valid/win_req.
//  frame_start, any state: fill_cnt<=0, state<=FILL, win_err<=0.
//    Band contents are not cleared; a request in flight still completes.
//  rst: band all 0, fill_cnt=0, state=FILL, win_data=0, win_valid=0, buf_ready=0, win_err=0.
//  rst mid-fill or mid-band: the next row accepted after release is written to band[0].
//  Arithmetic: unsigned pixel copy only. No saturation or sign handling.
// TESTING
//  (Defaults; pixel value = row*256+col.)
//  T1 Fill: rows 0..7 sent back-to-back -> in_ready=1 for 8 beats, buf_ready rises after beat 8,
//     in_ready=0 after that; in_valid held while READY is not accepted.
//  T2 Window: req (0,0) -> next cycle win_valid=1, [0][0]=0x0000, [3][27]=0x031B;
//     req (4,4) -> [0][0]=0x0404, [3][27]=0x071F.
//  T3 Slide: band_done, then send rows 8..11 -> FILL needs exactly 4 beats;
//     req (0,0) -> [0][0]=0x0400, [3][0]=0x0700.
//  T4 Collision: win_req(1,2)+band_done same cycle -> [0][0]=0x0102 (pre-slide), state=FILL.
//  T5 Errors: req ker_col=5 -> win_data=0, win_err=1; win_req in FILL -> no win_valid;
//     frame_start -> win_err=0, fill restarts at band[0].
//  T6 Reset: rst asserted after 3 of 8 rows -> all outputs 0; 8 new rows then give buf_ready
//     with row 0 = first post-reset row.

Source files
------------

// File: rtl/conv_band_buffer_if.sv
// Stream, window-request and window-response bundle of the conv row-band buffer.
// master = producer/consumer side, slave = the buffer.
interface conv_band_buffer_if #(
  parameter int DW       = 16,
  parameter int IMG_W    = 32,
  parameter int K        = 5,
  parameter int OUT_ROWS = 4
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int CW    = $clog2(K);

  logic                         frame_start;
  logic                         in_valid;
  logic                         in_ready;
  logic [IMG_W*DW-1:0]          in_row;
  logic                         buf_ready;
  logic                         win_req;
  logic [CW-1:0]                ker_row;
  logic [CW-1:0]                ker_col;
  logic                         win_valid;
  logic [OUT_ROWS*OUT_W*DW-1:0] win_data;
  logic                         win_err;
  logic                         band_done;

  modport master (
    output frame_start, in_valid, in_row, win_req, ker_row, ker_col, band_done,
    input  in_ready, buf_ready, win_valid, win_data, win_err
  );

  modport slave (
    input  frame_start, in_valid, in_row, win_req, ker_row, ker_col, band_done,
    output in_ready, buf_ready, win_valid, win_data, win_err
  );
endinterface

// File: rtl/conv_band_buffer.sv
// Row-band buffer for the conv MAC array: fills DEPTH rows, serves shifted
// OUT_ROWS x OUT_W windows, and slides by OUT_ROWS keeping the K-1 overlap rows.
module conv_band_buffer #(
  parameter int DW       = 16,
  parameter int IMG_W    = 32,
  parameter int K        = 5,
  parameter int OUT_ROWS = 4
) (
  input logic              clk,
  input logic              rst,
  conv_band_buffer_if.slave bus
);
  localparam int DEPTH = OUT_ROWS + K - 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int CW    = $clog2(K);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int RW    = IMG_W * DW;
  localparam int WW    = OUT_ROWS * OUT_W * DW;

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [DEPTH-1:0][RW-1:0] band_q, band_d;
  logic [WW-1:0]           win_data_q, win_data_d;
  logic                    win_valid_q, win_valid_d;
  logic                    win_err_q, win_err_d;

  logic                              off_err;
  logic [OUT_ROWS-1:0][OUT_W*DW-1:0] win_rows;

  // One extra bit so K itself is representable even when K is a power of two.
  assign off_err = ({1'b0, bus.ker_row} >= (CW+1)'(K)) ||
                   ({1'b0, bus.ker_col} >= (CW+1)'(K));

  for (genvar r = 0; r < OUT_ROWS; r++) begin : g_row
    logic [RW-1:0] row_sel;
    logic [RW-1:0] row_sh;
    always_comb begin
      row_sel = '0;
      for (int d = 0; d < DEPTH; d++)
        if (int'(bus.ker_row) + r == d) row_sel = band_q[d];
      row_sh = row_sel >> (DW * int'(bus.ker_col));
    end
    assign win_rows[r] = row_sh[OUT_W*DW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    band_d      = band_q;
    win_data_d  = win_data_q;
    win_valid_d = 1'b0;
    win_err_d   = win_err_q;
    if (bus.frame_start) begin
      fill_cnt_d = '0;
      state_d    = S_FILL;
      win_err_d  = 1'b0;
    end else if (state_q == S_READY) begin
      // Window reads band_q, so a same-cycle slide still sees the old rows.
      if (bus.win_req) begin
        win_valid_d = 1'b1;
        win_data_d  = off_err ? '0 : win_rows;
        if (off_err) win_err_d = 1'b1;
      end
      if (bus.band_done) begin
        for (int i = 0; i < K - 1; i++) band_d[i] = band_q[i + OUT_ROWS];
        fill_cnt_d = FW'(K - 1);
        state_d    = S_FILL;
      end
    end else if (bus.in_valid) begin
      for (int d = 0; d < DEPTH; d++)
        if (fill_cnt_q == FW'(d)) band_d[d] = bus.in_row;
      fill_cnt_d = fill_cnt_q + 1'b1;
      if (fill_cnt_q == FW'(DEPTH - 1)) state_d = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= '0;
      band_q      <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      win_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      band_q      <= band_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      win_err_q   <= win_err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_FILL) && !rst;
  assign bus.buf_ready = (state_q == S_READY);
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_err   = win_err_q;
endmodule

// File: tb/tb_conv_band_buffer.sv
// Directed bench for conv_band_buffer; pixel value = row*256+col.
module tb_conv_band_buffer;
  localparam int DW = 16, IMG_W = 32, K = 5, OUT_ROWS = 4;
  localparam int OUT_W = IMG_W - K + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_band_buffer_if bus ();
  conv_band_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  function automatic logic [IMG_W*DW-1:0] mk_row(int r);
    logic [IMG_W*DW-1:0] v;
    for (int c = 0; c < IMG_W; c++) v[c*DW +: DW] = DW'(r*256 + c);
    return v;
  endfunction

  function automatic logic [DW-1:0] wpx(int r, int c);
    logic [OUT_ROWS*OUT_W*DW-1:0] w;
    w = bus.win_data;
    return w[(r*OUT_W + c)*DW +: DW];
  endfunction

  task automatic idle();
    bus.frame_start = 0; bus.in_valid = 0; bus.in_row = '0; bus.win_req = 0;
    bus.ker_row = 0; bus.ker_col = 0; bus.band_done = 0;
  endtask

  task automatic send_row(int r);
    bus.in_valid = 1; bus.in_row = mk_row(r);
    @(negedge clk);
    bus.in_valid = 0;
  endtask

  task automatic request(int kr, int kc);
    bus.win_req = 1; bus.ker_row = 3'(kr); bus.ker_col = 3'(kc);
    @(negedge clk);
    bus.win_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL rst_buf_ready got=%b exp=0", bus.buf_ready); end
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL rst_win_valid got=%b exp=0", bus.win_valid); end
    checks++; if (bus.win_err !== 1'b0) begin failures++; $display("FAIL rst_win_err got=%b exp=0", bus.win_err); end
    checks++; if (bus.win_data !== '0) begin failures++; $display("FAIL rst_win_data nonzero"); end
    rst = 0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_fill();
    for (int b = 0; b < 8; b++) begin
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fill_in_ready beat=%0d got=%b exp=1", b, bus.in_ready); end
      checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL fill_buf_ready_early beat=%0d got=%b exp=0", b, bus.buf_ready); end
      send_row(b);
    end
    checks++; if (bus.buf_ready !== 1'b1) begin failures++; $display("FAIL fill_buf_ready got=%b exp=1", bus.buf_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready_ready got=%b exp=0", bus.in_ready); end
    // Held in_valid while READY must not disturb the band (checked by the windows below).
    send_row(99);
    send_row(98);
  endtask

  task automatic test_window();
    request(0, 0);
    checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL win00_valid got=%b exp=1", bus.win_valid); end
    checks++; if (wpx(0, 0) !== 16'h0000) begin failures++; $display("FAIL win00_r0c0 got=%h exp=0000", wpx(0, 0)); end
    checks++; if (wpx(3, 27) !== 16'h031B) begin failures++; $display("FAIL win00_r3c27 got=%h exp=031B", wpx(3, 27)); end
    @(negedge clk);
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL win_pulse got=%b exp=0", bus.win_valid); end
    checks++; if (wpx(3, 27) !== 16'h031B) begin failures++; $display("FAIL win_hold got=%h exp=031B", wpx(3, 27)); end
    request(4, 4);
    checks++; if (wpx(0, 0) !== 16'h0404) begin failures++; $display("FAIL win44_r0c0 got=%h exp=0404", wpx(0, 0)); end
    checks++; if (wpx(3, 27) !== 16'h071F) begin failures++; $display("FAIL win44_r3c27 got=%h exp=071F", wpx(3, 27)); end
    request(2, 1);
    checks++; if (wpx(1, 5) !== 16'h0306) begin failures++; $display("FAIL win21_r1c5 got=%h exp=0306", wpx(1, 5)); end
  endtask

  task automatic test_slide();
    bus.band_done = 1;
    @(negedge clk);
    bus.band_done = 0;
    checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL slide_buf_ready got=%b exp=0", bus.buf_ready); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL slide_early_ready beat=%0d got=%b exp=0", b, bus.buf_ready); end
      send_row(8 + b);
    end
    checks++; if (bus.buf_ready !== 1'b1) begin failures++; $display("FAIL slide_ready got=%b exp=1", bus.buf_ready); end
    request(0, 0);
    checks++; if (wpx(0, 0) !== 16'h0400) begin failures++; $display("FAIL slide_r0c0 got=%h exp=0400", wpx(0, 0)); end
    checks++; if (wpx(3, 0) !== 16'h0700) begin failures++; $display("FAIL slide_r3c0 got=%h exp=0700", wpx(3, 0)); end
    request(4, 0);
    checks++; if (wpx(0, 0) !== 16'h0800) begin failures++; $display("FAIL slide_new_r0c0 got=%h exp=0800", wpx(0, 0)); end
  endtask

  // Band now holds rows 4..11, so pre-slide band[1][2] is row 5 col 2.
  task automatic test_collision();
    bus.band_done = 1;
    request(1, 2);
    bus.band_done = 0;
    checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL coll_valid got=%b exp=1", bus.win_valid); end
    checks++; if (wpx(0, 0) !== 16'h0502) begin failures++; $display("FAIL coll_r0c0 got=%h exp=0502", wpx(0, 0)); end
    checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL coll_state got=%b exp=0", bus.buf_ready); end
    for (int b = 0; b < 4; b++) send_row(12 + b);
    checks++; if (bus.buf_ready !== 1'b1) begin failures++; $display("FAIL coll_refill got=%b exp=1", bus.buf_ready); end
    request(0, 0);
    checks++; if (wpx(0, 0) !== 16'h0800) begin failures++; $display("FAIL coll_post_r0c0 got=%h exp=0800", wpx(0, 0)); end
  endtask

  task automatic test_errors();
    request(0, 5);
    checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL err_valid got=%b exp=1", bus.win_valid); end
    checks++; if (bus.win_data !== '0) begin failures++; $display("FAIL err_data nonzero"); end
    checks++; if (bus.win_err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", bus.win_err); end
    request(1, 1);
    checks++; if (bus.win_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.win_err); end
    checks++; if (wpx(0, 0) !== 16'h0901) begin failures++; $display("FAIL err_then_ok got=%h exp=0901", wpx(0, 0)); end
    request(6, 0);
    checks++; if (bus.win_data !== '0) begin failures++; $display("FAIL err_row_data nonzero"); end
    bus.band_done = 1;
    @(negedge clk);
    bus.band_done = 0;
    request(0, 0);
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL fill_req_valid got=%b exp=0", bus.win_valid); end
    checks++; if (bus.win_data !== '0) begin failures++; $display("FAIL fill_req_held nonzero"); end
    bus.frame_start = 1;
    @(negedge clk);
    bus.frame_start = 0;
    checks++; if (bus.win_err !== 1'b0) begin failures++; $display("FAIL fs_err_clear got=%b exp=0", bus.win_err); end
    for (int b = 0; b < 7; b++) send_row(20 + b);
    checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL fs_refill_len got=%b exp=0", bus.buf_ready); end
    send_row(27);
    checks++; if (bus.buf_ready !== 1'b1) begin failures++; $display("FAIL fs_ready got=%b exp=1", bus.buf_ready); end
    request(0, 0);
    checks++; if (wpx(0, 0) !== 16'h1400) begin failures++; $display("FAIL fs_r0c0 got=%h exp=1400", wpx(0, 0)); end
  endtask

  task automatic test_reset_mid();
    bus.frame_start = 1;
    @(negedge clk);
    bus.frame_start = 0;
    for (int b = 0; b < 3; b++) send_row(30 + b);
    rst = 1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", bus.in_ready); end
    rst = 0;
    @(negedge clk);
    checks++; if (bus.win_data !== '0) begin failures++; $display("FAIL mid_rst_data nonzero"); end
    checks++; if (bus.buf_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_buf_ready got=%b exp=0", bus.buf_ready); end
    for (int b = 0; b < 8; b++) send_row(40 + b);
    checks++; if (bus.buf_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", bus.buf_ready); end
    request(0, 0);
    checks++; if (wpx(0, 0) !== 16'h2800) begin failures++; $display("FAIL mid_rst_r0c0 got=%h exp=2800", wpx(0, 0)); end
    checks++; if (wpx(3, 27) !== 16'h2B1B) begin failures++; $display("FAIL mid_rst_r3c27 got=%h exp=2B1B", wpx(3, 27)); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_window();
    test_slide();
    test_collision();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
